dma_priority_arbiter: RTL
=========================

// Module: dma_priority_arbiter
// PURPOSE
//  Parametrised N-channel DMA request arbiter; next generation of the fixed 4-channel priority logic.
//  Resolves DREQ against mask and programmable fixed/rotating priority, runs the HRQ/HLDA hold
//  handshake with the CPU, and drives one-hot DACK to the winning channel until service completes.
//  Sits between the channel register file and the timing-control FSM.
// PARAMETERS
//  NUM_CH  4                 number of DMA channels (2..16)
//  CH_W    $clog2(NUM_CH)    channel-index width (localparam, not overridable)
// PORTS
//  CLK               in   1            single clock; all state updates on posedge
//  RESET             in   1            synchronous, active-high reset
//  DREQ              in   NUM_CH       channel requests, polarity set by dreqActiveLow
//  dreqActiveLow     in   1            1: DREQ active-low; 0: active-high
//  maskReg           in   NUM_CH       1 = channel masked (ignored by arbitration)
//  controllerEnable  in   1            0 = no new arbitration; current service runs to completion
//  rotatingPriority  in   1            0 = fixed, 1 = rotating priority
//  HLDA              in   1            hold acknowledge from CPU
//  serviceDone       in   1            1-cycle pulse from timing control: transfer/EOP finished
//  HRQ               out  1            hold request to CPU
//  DACK              out  NUM_CH       one-hot acknowledge, active-high
//  activeChannel     out  CH_W         index of latched winner
//  channelValid      out  1            1 while in SERVICE
//  priorityOrder     out  NUM_CH*CH_W  slot k = channel at priority k; slot 0 = highest, in LSBs
// BEHAVIOUR
//  Reset values: HRQ=0, DACK=0, activeChannel=0, channelValid=0, state=IDLE.
//   priorityOrder slot k = k, e.g. NUM_CH=4 -> 8'b11_10_01_00.
//   All values hold on the first edge with RESET high, and in every cycle while RESET is held.
//  Effective request: req[i] = (DREQ[i] ^ dreqActiveLow) & ~maskReg[i].
//  Winner: the first slot of priorityOrder, scanning from slot 0, whose channel has req set.
//  FSM IDLE -> HOLD_REQ -> SERVICE -> IDLE; all outputs registered.
//   IDLE:
//    - if controllerEnable and |req: latch the winner into activeChannel, set HRQ, go to HOLD_REQ.
//      HRQ is visible 1 cycle after the request is sampled.
//   HOLD_REQ:
//    - the winner stays latched; later higher-priority requests do not displace it.
//    - HLDA=1: go to SERVICE; DACK[activeChannel]=1 and channelValid=1 on the next cycle.
//    - the latched channel's req drops before HLDA: clear HRQ, return to IDLE, no priority update.
//   SERVICE:
//    - HRQ, DACK and channelValid held; a new mask, DREQ or controllerEnable does not preempt.
//    - serviceDone=1, or HLDA dropping: go to IDLE; DACK, HRQ and channelValid clear next cycle.
//      If rotatingPriority=1, priorityOrder updates on that same edge.
//  Rotation: after serving channel c, slot k = (c+1+k) mod NUM_CH, so c becomes lowest priority.
//   Fixed mode never modifies priorityOrder.
//   Changing rotatingPriority 1->0 restores the reset order on the next edge.
//  Back-to-back: at least one IDLE cycle (HRQ low) between services.
//   A request arriving together with serviceDone is arbitrated in that IDLE cycle.
//  Boundaries:
//   - all channels masked: stay in IDLE.
//   - serviceDone outside SERVICE: ignored.
//   - channel index wraps modulo NUM_CH.
//   - RESET mid-service: DACK and HRQ drop on the next edge and priorityOrder returns to the reset order.
// STRUCTURE
//  Shared package dma_pkg:
//   - arb_state_e enum {IDLE, HOLD_REQ, SERVICE};
//   - function reset_priority_order(NUM_CH) for reuse by the SVA checkers.
//  Sub-module dma_priority_resolver: combinational; priorityOrder + req -> winner index + found flag.
//  This file holds the FSM, the latched winner, the order register and the rotate logic.
// TESTING
//  1 RESET 2 cycles, NUM_CH=4 -> priorityOrder=8'b11_10_01_00, HRQ=0, DACK=4'b0000, channelValid=0.
//  2 Fixed mode, DREQ=4'b1010 high-active, HLDA 2 cycles after HRQ
//     -> activeChannel=1, DACK=4'b0010; serviceDone -> DACK=0, order unchanged.
//  3 Rotating mode, serve ch1 -> priorityOrder=8'b01_00_11_10;
//     then DREQ=4'b0011 -> ch0 granted before ch1.
//  4 maskReg=4'b0100, DREQ=4'b0100 -> HRQ stays 0.
//     Unmask during SERVICE of ch3 -> ch3 keeps DACK until serviceDone.
//  5 DREQ ch2 drops while in HOLD_REQ, before HLDA -> HRQ=0 next cycle, DACK never asserted.
//  6 NUM_CH=8: RESET asserted mid-SERVICE -> DACK=8'h00 and HRQ=0 next cycle,
//     priorityOrder = {3'd7,3'd6,...,3'd0}.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA priority arbiter and its checkers.
package dma_pkg;

    localparam int unsigned MAX_ORDER_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        SERVICE  = 2'd2
    } arb_state_e;

    // Reset priority order: slot k holds channel k, slot 0 in the LSBs.
    function automatic logic [MAX_ORDER_W-1:0] reset_priority_order(input int unsigned num_ch);
        logic [MAX_ORDER_W-1:0] order;
        int unsigned            w;
        order = '0;
        w     = $clog2(num_ch);
        for (int unsigned k = 0; k < num_ch; k++) begin
            order = order | (MAX_ORDER_W'(k) << (k * w));
        end
        return order;
    endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the channel register file, the CPU hold handshake and the arbiter.
interface dma_priority_arbiter_if #(
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]      DREQ;
    logic                   dreqActiveLow;
    logic [NUM_CH-1:0]      maskReg;
    logic                   controllerEnable;
    logic                   rotatingPriority;
    logic                   HLDA;
    logic                   serviceDone;
    logic                   HRQ;
    logic [NUM_CH-1:0]      DACK;
    logic [CH_W-1:0]        activeChannel;
    logic                   channelValid;
    logic [NUM_CH*CH_W-1:0] priorityOrder;

    modport master (
        output DREQ, dreqActiveLow, maskReg, controllerEnable, rotatingPriority,
        output HLDA, serviceDone,
        input  HRQ, DACK, activeChannel, channelValid, priorityOrder
    );

    modport slave (
        input  DREQ, dreqActiveLow, maskReg, controllerEnable, rotatingPriority,
        input  HLDA, serviceDone,
        output HRQ, DACK, activeChannel, channelValid, priorityOrder
    );

endinterface

// File: rtl/dma_priority_resolver.sv
// Combinational winner search: first priority slot whose channel is requesting.
module dma_priority_resolver #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH*$clog2(NUM_CH)-1:0] order,
    input  logic [NUM_CH-1:0]                req,
    output logic [$clog2(NUM_CH)-1:0]        winner_c,
    output logic                             found_c
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0] slot;

    // Scan from slot 0 (highest priority) and keep the first requesting channel.
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        slot     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            slot = order[k*CH_W +: CH_W];
            if (!found_c && req[slot]) begin
                winner_c = slot;
                found_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// N-channel DMA request arbiter: hold handshake FSM, latched winner and fixed/rotating priority order.
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    dma_priority_arbiter_if.slave bus
);
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned ORDER_W = NUM_CH * CH_W;

    localparam logic [ORDER_W-1:0] RESET_ORDER = ORDER_W'(reset_priority_order(NUM_CH));

    localparam logic [1:0] ST_IDLE     = 2'(IDLE);
    localparam logic [1:0] ST_HOLD_REQ = 2'(HOLD_REQ);
    localparam logic [1:0] ST_SERVICE  = 2'(SERVICE);

    logic [1:0]         state_q, state_d;
    logic               hrq_q, hrq_d;
    logic [NUM_CH-1:0]  dack_q, dack_d;
    logic [CH_W-1:0]    active_q, active_d;
    logic               valid_q, valid_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic [ORDER_W-1:0] rotated_order;

    logic [NUM_CH-1:0]  req;
    logic [CH_W-1:0]    winner;
    logic               found;
    int unsigned        idx;

    assign req = (bus.DREQ ^ {NUM_CH{bus.dreqActiveLow}}) & ~bus.maskReg;

    dma_priority_resolver #(
        .NUM_CH (NUM_CH)
    ) u_resolver (
        .order    (order_q),
        .req      (req),
        .winner_c (winner),
        .found_c  (found)
    );

    // Order after serving the latched channel: it drops to the lowest slot.
    always_comb begin
        rotated_order = '0;
        idx           = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(active_q) + 32'd1 + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            rotated_order[k*CH_W +: CH_W] = CH_W'(idx);
        end
    end

    // Next-state and next-output decode for the hold handshake.
    always_comb begin
        state_d  = state_q;
        hrq_d    = hrq_q;
        dack_d   = dack_q;
        active_d = active_q;
        valid_d  = valid_q;
        // Fixed mode always sits on the reset order, which also restores it when rotation is turned off.
        order_d  = bus.rotatingPriority ? order_q : RESET_ORDER;

        case (state_q)
            ST_IDLE: begin
                if (bus.controllerEnable && found) begin
                    active_d = winner;
                    hrq_d    = 1'b1;
                    state_d  = ST_HOLD_REQ;
                end
            end
            ST_HOLD_REQ: begin
                if (bus.HLDA) begin
                    dack_d  = NUM_CH'(1) << active_q;
                    valid_d = 1'b1;
                    state_d = ST_SERVICE;
                end else if (!req[active_q]) begin
                    hrq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.serviceDone || !bus.HLDA) begin
                    hrq_d   = 1'b0;
                    dack_d  = '0;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                    if (bus.rotatingPriority) begin
                        order_d = rotated_order;
                    end
                end
            end
            default: begin
                hrq_d   = 1'b0;
                dack_d  = '0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            hrq_q    <= 1'b0;
            dack_q   <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            order_q  <= RESET_ORDER;
        end else begin
            state_q  <= state_d;
            hrq_q    <= hrq_d;
            dack_q   <= dack_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            order_q  <= order_d;
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = dack_q;
    assign bus.activeChannel = active_q;
    assign bus.channelValid  = valid_q;
    assign bus.priorityOrder = order_q;

endmodule
